// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR write burst generator: FSM encoding,
// 4 KB boundary constant and beat-size helpers.
package ddr_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_NEXT = 2'd3
    } wr_state_e;

    localparam int BOUNDARY_4K = 4096;

    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int beat_size_log2(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ddr_burst_len_calc.sv
// Next burst length in beats from the burst start address and remaining beats.
// The 4 KB limit is applied only when DDR_WR_4K_SPLIT_EN is defined.
module ddr_burst_len_calc
    import ddr_axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST_LEN  = 64
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]               remaining,
    output logic [8:0]                beats
);
    localparam int          BYTE_SHIFT = beat_size_log2(AXI_DATA_WIDTH);
    localparam logic [31:0] MAX_BEATS  = 32'(MAX_BURST_LEN);

    logic [31:0] beats_cap;
    logic [31:0] beats_to_4k;
    logic        unused_bits;

    always_comb begin
        // Start addresses are beat aligned, so the shift is exact.
        beats_to_4k = (32'(BOUNDARY_4K) - 32'(addr[11:0])) >> BYTE_SHIFT;
        beats_cap   = (remaining < MAX_BEATS) ? remaining : MAX_BEATS;
`ifdef DDR_WR_4K_SPLIT_EN
        if (beats_to_4k < beats_cap) beats_cap = beats_to_4k;
`else
`endif
        beats = beats_cap[8:0];
    end

    assign unused_bits = ^{addr[AXI_ADDR_WIDTH-1:12], beats_cap[31:9], beats_to_4k};

endmodule

// File: rtl/ddr_wr_burst_gen.sv
// Splits a write job into AXI bursts: issues one command per burst, then
// passes source beats straight through to the write master. Optional macro: DDR_WR_4K_SPLIT_EN.
module ddr_wr_burst_gen
    import ddr_axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST_LEN  = 64
) (
    input  logic                      axi_clk,
    input  logic                      reset,
    input  logic                      wr_start,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_base_addr,
    input  logic [31:0]               wr_total_beats,
    output logic                      wr_busy,
    output logic                      wr_done,
    input  logic [AXI_DATA_WIDTH-1:0] usr_wr_data,
    input  logic                      usr_wr_valid,
    output logic                      usr_wr_ready,
    input  logic                      axi_aw_ready,
    output logic                      axi_aw_req_en,
    output logic [7:0]                axi_aw_burst_len,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    input  logic                      axi_w_ready,
    output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    output logic                      axi_w_valid,
    output logic                      axi_w_last,
    output wr_state_e                 dbg_state
);
    localparam int BYTE_SHIFT = beat_size_log2(AXI_DATA_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((AXI_ADDR_WIDTH'(1) << BYTE_SHIFT) - AXI_ADDR_WIDTH'(1));

    wr_state_e                 state, next_state;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, calc_addr, burst_bytes;
    logic [31:0]               remaining_q, calc_remaining;
    logic [8:0]                burst_beats_q, beat_cnt_q, calc_beats;
    logic [7:0]                len_q;
    logic                      done_q, last_beat, beat_xfer;

    // In IDLE the calculator sees the incoming job, otherwise the running one.
    assign calc_addr      = (state == ST_IDLE) ? (wr_base_addr & ALIGN_MASK) : addr_q;
    assign calc_remaining = (state == ST_IDLE) ? wr_total_beats : remaining_q;

    ddr_burst_len_calc #(
        .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len_calc (
        .addr     (calc_addr),
        .remaining(calc_remaining),
        .beats    (calc_beats)
    );

    assign burst_bytes = AXI_ADDR_WIDTH'(burst_beats_q) << BYTE_SHIFT;
    assign last_beat   = (beat_cnt_q == burst_beats_q - 9'd1);
    // Handshakes: a command or beat moves on the rising edge where both valid
    // (req_en / w_valid) and ready are high; valid never waits on ready.
    assign beat_xfer   = axi_w_valid && axi_w_ready;

    always_comb begin
        next_state    = state;
        axi_aw_req_en = 1'b0;
        axi_w_valid   = 1'b0;
        axi_w_last    = 1'b0;
        usr_wr_ready  = 1'b0;
        case (state)
            ST_IDLE: if (wr_start && wr_total_beats != 32'd0) next_state = ST_CMD;
            ST_CMD: begin
                axi_aw_req_en = 1'b1;
                if (axi_aw_ready) next_state = ST_DATA;
            end
            ST_DATA: begin
                axi_w_valid  = usr_wr_valid;
                usr_wr_ready = axi_w_ready;
                axi_w_last   = last_beat;
                if (usr_wr_valid && axi_w_ready && last_beat) next_state = ST_NEXT;
            end
            ST_NEXT: next_state = (remaining_q != 32'd0) ? ST_CMD : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            burst_beats_q <= '0;
            beat_cnt_q    <= '0;
            len_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_start) begin
                        if (wr_total_beats != 32'd0) begin
                            addr_q        <= calc_addr;
                            remaining_q   <= wr_total_beats;
                            burst_beats_q <= calc_beats;
                            len_q         <= 8'(calc_beats - 9'd1);
                            beat_cnt_q    <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (beat_xfer) begin
                        remaining_q <= remaining_q - 32'd1;
                        if (last_beat) begin
                            beat_cnt_q <= '0;
                            addr_q     <= addr_q + burst_bytes;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 9'd1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (remaining_q != 32'd0) begin
                        burst_beats_q <= calc_beats;
                        len_q         <= 8'(calc_beats - 9'd1);
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_busy          = (state != ST_IDLE);
    assign wr_done          = done_q;
    assign axi_aw_addr      = addr_q;
    assign axi_aw_burst_len = len_q;
    assign axi_w_data       = usr_wr_data;
    assign dbg_state        = state;

endmodule
